// File: rtl/regbank_pkg.sv
// Shared types and helpers for the 32x32 register bank write-back path.
//   REG_N / REG_AW / XLEN : bank geometry
//   reg_addr_t, word_t    : register address and data word types
//   onehot_rd()           : address -> one-hot write enable over x1..x31
//                           (x0 maps to all-zero, so writes to x0 vanish)
package regbank_pkg;

  localparam int REG_N  = 32;
  localparam int REG_AW = 5;
  localparam int XLEN   = 32;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]   word_t;

  function automatic logic [31:1] onehot_rd(input reg_addr_t a);
    logic [31:1] r;
    r = '0;
    for (int i = 1; i < REG_N; i++)
      if (a == REG_AW'(i)) r[i] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/regbank_wb_ctrl_rr_arbiter.sv
// Round-robin arbiter for the write-back port.
//   clk, reset : clock, async active-high reset
//   req        : NREQ request bits
//   advance    : a transfer happened this cycle; move pointer past the winner
//   gnt        : one-hot grant (combinational), zero when no request
//   gnt_idx    : binary index of the granted requester
// The search starts at rr_ptr and wraps, so the last winner becomes lowest
// priority and any waiting requester is served within NREQ-1 cycles.
module rr_arbiter #(
  parameter  int NREQ = 3,
  localparam int RR_W = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] gnt,
  output logic [RR_W-1:0] gnt_idx
);

  logic [RR_W-1:0] rr_ptr;

  always_comb begin
    logic found;
    int   idx;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = RR_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      rr_ptr <= '0;
    else if (advance)
      rr_ptr <= (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + RR_W'(1);
  end

endmodule

// File: rtl/regbank_wb_ctrl.sv
// Write-back controller for the 32x32 register bank.
// Arbitrates NREQ write-back requesters onto the single bank write port,
// drives registered one-hot write enable and data, and keeps the per-register
// busy scoreboard used by decode for RAW/WAW interlock.
//   clk, reset        : clock, async active-high reset
//   wb_valid/wb_ready : per-requester handshake (ready is combinational)
//   wb_rd, wb_data    : per-requester destination and data
//   issue_valid/rd    : decode issues a writer of issue_rd (sets busy)
//   flush             : clears the scoreboard at the next edge
//   busy [31:1]       : outstanding-write bitmap
//   waw_err           : sticky, issue to an already-busy register
//   addrw, wdata      : registered bank write port
// Optional: define REGBANK_BYPASS_EN to add read-port forwarding
//   (addra/addrb, outa_rb/outb_rb in; outa/outb out).
module regbank_wb_ctrl
  import regbank_pkg::*;
#(
  parameter  int NREQ = 3,
  localparam int RR_W = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      wb_valid,
  output logic [NREQ-1:0]      wb_ready,
  input  reg_addr_t [NREQ-1:0] wb_rd,
  input  word_t [NREQ-1:0]     wb_data,
  input  logic                 issue_valid,
  input  reg_addr_t            issue_rd,
  input  logic                 flush,
  output logic [31:1]          busy,
  output logic                 waw_err,
  output logic [31:1]          addrw,
  output word_t                wdata
`ifdef REGBANK_BYPASS_EN
  ,
  input  reg_addr_t            addra,
  input  reg_addr_t            addrb,
  input  word_t                outa_rb,
  input  word_t                outb_rb,
  output word_t                outa,
  output word_t                outb
`endif
);

  logic [NREQ-1:0] gnt;
  logic [RR_W-1:0] gnt_idx;
  logic            xfer;
  reg_addr_t       sel_rd;
  word_t           sel_data;
  logic [31:1]     set_v, clr_v, busy_nxt;
  logic            waw_hit;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (wb_valid),
    .advance (xfer),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Grant is held off during reset so nothing is accepted while state is cleared.
  assign wb_ready = reset ? '0 : gnt;
  assign xfer     = |(wb_valid & wb_ready);

  always_comb begin
    sel_rd   = wb_rd[gnt_idx];
    sel_data = wb_data[gnt_idx];
  end

  // Scoreboard next state: set beats clear on the same register, flush beats both.
  always_comb begin
    set_v    = issue_valid ? onehot_rd(issue_rd) : '0;
    clr_v    = xfer ? onehot_rd(sel_rd) : '0;
    waw_hit  = |(set_v & busy & ~clr_v);
    busy_nxt = flush ? '0 : ((busy & ~clr_v) | set_v);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addrw   <= '0;
      wdata   <= '0;
      busy    <= '0;
      waw_err <= 1'b0;
    end else begin
      // x0 transfers are accepted but produce an all-zero enable.
      addrw <= xfer ? onehot_rd(sel_rd) : '0;
      if (xfer) wdata <= sel_data;
      busy <= busy_nxt;
      if (waw_hit) waw_err <= 1'b1;
    end
  end

`ifdef REGBANK_BYPASS_EN
  // Forward the write sitting in the output register to the read ports so
  // decode sees it in the same cycle the bank is written.
  assign outa = (|(onehot_rd(addra) & addrw)) ? wdata : outa_rb;
  assign outb = (|(onehot_rd(addrb) & addrw)) ? wdata : outb_rb;
`endif

endmodule

// File: tb/tb_regbank_wb_ctrl.sv
module tb_regbank_wb_ctrl;
  import regbank_pkg::*;

  localparam int NREQ = 3;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [NREQ-1:0]       wb_valid;
  logic [NREQ-1:0]       wb_ready;
  logic [NREQ-1:0][4:0]  wb_rd;
  logic [NREQ-1:0][31:0] wb_data;
  logic                  issue_valid;
  logic [4:0]            issue_rd;
  logic                  flush;
  logic [31:1]           busy;
  logic                  waw_err;
  logic [31:1]           addrw;
  logic [31:0]           wdata;
`ifdef REGBANK_BYPASS_EN
  logic [4:0]  addra, addrb;
  logic [31:0] outa_rb, outb_rb, outa, outb;
`endif

  always #5 clk = ~clk;

  regbank_wb_ctrl #(.NREQ(NREQ)) dut (
    .clk         (clk),
    .reset       (reset),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .flush       (flush),
    .busy        (busy),
    .waw_err     (waw_err),
    .addrw       (addrw),
    .wdata       (wdata)
`ifdef REGBANK_BYPASS_EN
    ,
    .addra       (addra),
    .addrb       (addrb),
    .outa_rb     (outa_rb),
    .outb_rb     (outb_rb),
    .outa        (outa),
    .outb        (outb)
`endif
  );

  typedef struct {
    logic [31:0] addrw;
    logic [31:0] wdata;
    logic [31:0] busy;
    logic        waw;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // reference model state
  int          m_rr;
  logic [31:0] m_busy, m_wdata;
  logic        m_waw;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rr = 0; m_busy = '0; m_wdata = '0; m_waw = 1'b0;
    q.delete();
  endtask

  task automatic idle();
    wb_valid = '0; wb_rd = '0; wb_data = '0;
    issue_valid = 1'b0; issue_rd = '0; flush = 1'b0;
  endtask

  // Check the combinational grant, predict the next-edge outputs into the
  // scoreboard, clock once, then pop and compare.
  task automatic step(input string tag);
    int          g;
    logic [31:0] addr_e, clr, set;
    exp_t        e;
    #1;
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (m_rr + k) % NREQ;
      if (g < 0 && wb_valid[idx]) g = idx;
    end
    chk({tag, ".ready"}, 32'(wb_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
    addr_e = '0; clr = '0;
    if (g >= 0) begin
      if (wb_rd[g] != 0) begin
        addr_e = 32'd1 << wb_rd[g];
        clr    = addr_e;
      end
      m_wdata = wb_data[g];
      m_rr    = (g + 1) % NREQ;
    end
    set = (issue_valid && issue_rd != 0) ? (32'd1 << issue_rd) : 32'd0;
    if ((set & m_busy & ~clr) != 0) m_waw = 1'b1;
    m_busy = flush ? 32'd0 : ((m_busy & ~clr) | set);
    e.addrw = addr_e; e.wdata = m_wdata; e.busy = m_busy; e.waw = m_waw;
    q.push_back(e);
    @(posedge clk); #1;
    e = q.pop_front();
    chk({tag, ".addrw"}, {addrw, 1'b0}, e.addrw);
    chk({tag, ".wdata"}, wdata, e.wdata);
    chk({tag, ".busy"},  {busy, 1'b0},  e.busy);
    chk({tag, ".waw"},   32'(waw_err),  32'(e.waw));
  endtask

  initial begin
    idle();
`ifdef REGBANK_BYPASS_EN
    addra = '0; addrb = '0; outa_rb = '0; outb_rb = '0;
`endif
    model_reset();
    // reset state, ready gated while reset is high
    wb_valid[1] = 1'b1;
    #2;
    chk("rst.ready", 32'(wb_ready), 32'd0);
    chk("rst.addrw", {addrw, 1'b0}, 32'd0);
    chk("rst.wdata", wdata, 32'd0);
    chk("rst.busy",  {busy, 1'b0}, 32'd0);
    chk("rst.waw",   32'(waw_err), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle();

    // reset mid-transfer, with a busy bit already set
    issue_valid = 1'b1; issue_rd = 5'd5;
    step("pre");
    idle();
    wb_valid[0] = 1'b1; wb_rd[0] = 5'd5; wb_data[0] = 32'hDEADBEEF;
    @(posedge clk);
    reset = 1'b1;
    #1;
    chk("midrst.addrw", {addrw, 1'b0}, 32'd0);
    chk("midrst.wdata", wdata, 32'd0);
    chk("midrst.busy",  {busy, 1'b0}, 32'd0);
    chk("midrst.ready", 32'(wb_ready), 32'd0);
    idle();
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    step("postrst");

    // single write
    issue_valid = 1'b1; issue_rd = 5'd7;
    step("iss7");
    idle();
    wb_valid[1] = 1'b1; wb_rd[1] = 5'd7; wb_data[1] = 32'h12345678;
    step("wb7");
    idle();
    step("idle7");

    // round-robin with all three held valid
    wb_valid = 3'b111;
    wb_rd[0] = 5'd1; wb_rd[1] = 5'd2; wb_rd[2] = 5'd3;
    wb_data[0] = 32'hA0; wb_data[1] = 32'hA1; wb_data[2] = 32'hA2;
    repeat (6) step("rr");
    // requester 1 and 0 only: after 2 wins, 0 must beat 1
    idle();
    wb_valid[2] = 1'b1; wb_rd[2] = 5'd3; wb_data[2] = 32'hB2;
    step("rr2");
    wb_valid = 3'b011; wb_rd[0] = 5'd1; wb_rd[1] = 5'd2;
    wb_data[0] = 32'hB0; wb_data[1] = 32'hB1; wb_valid[2] = 1'b0;
    step("rr0");
    step("rr1");
    idle();

    // x0 write and same-cycle set/clear
    wb_valid[0] = 1'b1; wb_rd[0] = 5'd0; wb_data[0] = 32'hFFFFFFFF;
    step("x0");
    idle();
    wb_valid[2] = 1'b1; wb_rd[2] = 5'd9; wb_data[2] = 32'h99;
    issue_valid = 1'b1; issue_rd = 5'd9;
    step("setclr9");
    idle();
    step("hold");

    // WAW, then flush alongside a transfer
    issue_valid = 1'b1; issue_rd = 5'd4;
    step("waw1");
    step("waw2");
    idle();
    flush = 1'b1;
    wb_valid[0] = 1'b1; wb_rd[0] = 5'd3; wb_data[0] = 32'h33;
    step("flush");
    idle();
    step("postflush");

`ifdef REGBANK_BYPASS_EN
    wb_valid[1] = 1'b1; wb_rd[1] = 5'd10; wb_data[1] = 32'hA5A5A5A5;
    step("byp");
    idle();
    addra = 5'd10; outa_rb = 32'd0; addrb = 5'd0; outb_rb = 32'h11112222;
    #1;
    chk("byp.outa", outa, 32'hA5A5A5A5);
    chk("byp.outb", outb, 32'h11112222);
    addra = 5'd11; outa_rb = 32'h5555;
    #1;
    chk("byp.outa_miss", outa, 32'h5555);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regbank_wb_ctrl.md
Name: regbank_wb_ctrl

Overview:
Write-back controller for the 32x32 register bank. Arbitrates up to NREQ write-back requesters (ALU, load unit, mul/div, CSR) onto the bank's single write port with round-robin fairness. Drives the bank's one-hot write enable and data from registered outputs. Keeps a per-register busy scoreboard that the decode stage uses for RAW/WAW interlock.

Parameters:
NREQ, 3, number of write-back requesters (2..8)
RR_W, $clog2(NREQ), width of round-robin pointer (derived, not overridable)

Ports:
clk  in  1  clock
reset  in  1  asynchronous reset, active-high
wb_valid  in  NREQ  requester i has a write-back
wb_ready  out  NREQ  requester i is granted this cycle (combinational)
wb_rd  in  NREQ x 5  destination register per requester
wb_data  in  NREQ x 32  write data per requester
issue_valid  in  1  decode issues an instruction that writes issue_rd
issue_rd  in  5  destination of the issued instruction
flush  in  1  pipeline flush; clears scoreboard
busy  out  31 [31:1]  scoreboard bitmap, bit i = write to x[i] outstanding
waw_err  out  1  sticky: issue to an already-busy register
addrw  out  31 [31:1]  one-hot write enable to register bank (registered)
wdata  out  32  write data to register bank (registered)

Behaviour:
- Reset (async, reset=1): addrw=0, wdata=0, busy=0, waw_err=0, rr_ptr=0. wb_ready is 0 while reset is asserted.
- Grant:
  - Exactly one requester is granted per cycle when any wb_valid=1. Search starts at rr_ptr and wraps modulo NREQ.
  - wb_ready[g]=1 only for the granted index g. All other wb_ready bits are 0.
  - A transfer occurs when wb_valid[g]&wb_ready[g].
  - Requesters must hold valid/rd/data stable until accepted.
- rr_ptr: on a transfer, rr_ptr <= (g+1) mod NREQ. With no transfer it holds.
- Write output, 1-cycle latency:
  - Transfer accepted at edge N: addrw = onehot(wb_rd[g]) and wdata = wb_data[g] during cycle N..N+1. The bank writes at edge N+1.
  - No transfer: addrw <= 0. wdata holds its previous value.
  - wb_rd=0: the transfer is accepted and addrw <= 0, so no write occurs. It does not affect busy.
- Scoreboard:
  - Set: issue_valid & issue_rd!=0 sets busy[issue_rd] at the next edge.
  - Clear: a transfer with wb_rd=r!=0 clears busy[r] at the next edge, i.e. together with the addrw assertion.
  - Same register set and cleared in one cycle: set wins (busy stays 1).
  - issue_valid to a register already busy (and not cleared this cycle) sets waw_err. waw_err is cleared only by reset.
  - flush: busy <= 0 at the next edge, taking priority over set and clear. flush does not cancel a transfer in the same cycle or the registered addrw already pending.
- Only one write port exists, so there are no simultaneous writes. Multiple valid requesters are served one per cycle in RR order. A waiting requester waits at most NREQ-1 cycles.

Optional Feature:
REGBANK_BYPASS_EN
- Defined: adds ports addra, addrb (in, 5), outa_rb, outb_rb (in, 32), outa, outb (out, 32).
  - outa = wdata if addra!=0 and addrw[addra]=1, else outa_rb. outb is the same using addrb/outb_rb.
  - This forwards the in-flight registered write to the read ports in the same cycle.
- Not defined: these ports do not exist. Decode must stall on busy until the write reaches the bank, one cycle longer.

Decomposition:
- Shared package regbank_pkg:
  - REG_N=32, REG_AW=5, XLEN=32.
  - typedef logic [REG_AW-1:0] reg_addr_t.
  - typedef logic [XLEN-1:0] word_t.
  - function onehot_rd(reg_addr_t) returning logic [31:1].
- One sub-module: rr_arbiter (NREQ req in, one-hot grant out, rr_ptr register, advance input). Scoreboard, output registers and bypass stay in the top.

Test Plan:
- Reset mid-transfer: wb_valid[0]=1, wb_rd=5, wb_data=0xDEADBEEF, reset pulsed on the accept edge -> addrw=0, wdata=0, busy=0 immediately. No write observed after reset is released.
- Single write: issue_rd=7 then req1 rd=7 data=0x12345678 -> busy[7]=1 the cycle after issue. On acceptance, next cycle addrw=1<<7, wdata=0x12345678, busy[7]=0.
- Round-robin: all three valid continuously, rd=1,2,3 -> grants 0,1,2,0,...; addrw sequence bits 1,2,3. After grant 2, a new requester-0 request is granted before requester 1.
- x0 and same-cycle conflict: req rd=0 data=0xFFFFFFFF -> accepted, addrw=0. Issue rd=9 in the same cycle as write-back rd=9 -> busy[9]=1 and waw_err stays 0 (only when busy[9] was 0 beforehand).
- WAW and flush: issue rd=4 twice with no write-back between -> waw_err=1 sticky. flush=1 -> busy=0 next edge, waw_err remains 1.
- REGBANK_BYPASS_EN: write rd=10 data=0xA5A5A5A5 with addra=10 and outa_rb=0 in the addrw cycle -> outa=0xA5A5A5A5. addrb=0 -> outb=outb_rb.
